// File: rtl/decode_pipe_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, field slices,
// control-field widths and encodings, and the decoded control word.
package decode_pipe_pkg;

    localparam int INST_W      = 32;
    localparam int REG_FIELD_W = 5;

    localparam int W_OPCODE  = 6;
    localparam int W_FUNCT   = 6;
    localparam int W_IMM_EXT = 1;
    localparam int W_IMM     = 16;
    localparam int W_JADDR   = 26;
    localparam int W_PC_SRC  = 2;
    localparam int W_MEM_CMD = 2;
    localparam int W_ALU_SRC = 2;
    localparam int W_REG_SRC = 1;

    localparam logic [W_OPCODE-1:0] OP_RTYPE = 6'h00;
    localparam logic [W_OPCODE-1:0] OP_J     = 6'h02;
    localparam logic [W_OPCODE-1:0] OP_BEQ   = 6'h04;
    localparam logic [W_OPCODE-1:0] OP_ADDI  = 6'h08;
    localparam logic [W_OPCODE-1:0] OP_ADDIU = 6'h09;
    localparam logic [W_OPCODE-1:0] OP_SLTI  = 6'h0A;
    localparam logic [W_OPCODE-1:0] OP_SLTIU = 6'h0B;
    localparam logic [W_OPCODE-1:0] OP_ANDI  = 6'h0C;
    localparam logic [W_OPCODE-1:0] OP_ORI   = 6'h0D;
    localparam logic [W_OPCODE-1:0] OP_LW    = 6'h23;
    localparam logic [W_OPCODE-1:0] OP_SW    = 6'h2B;

    localparam logic [W_FUNCT-1:0] F_SLL   = 6'h00;
    localparam logic [W_FUNCT-1:0] F_SRL   = 6'h02;
    localparam logic [W_FUNCT-1:0] F_BREAK = 6'h0D;
    localparam logic [W_FUNCT-1:0] F_ADD   = 6'h20;
    localparam logic [W_FUNCT-1:0] F_ADDU  = 6'h21;
    localparam logic [W_FUNCT-1:0] F_SUB   = 6'h22;
    localparam logic [W_FUNCT-1:0] F_SUBU  = 6'h23;
    localparam logic [W_FUNCT-1:0] F_AND   = 6'h24;
    localparam logic [W_FUNCT-1:0] F_OR    = 6'h25;
    localparam logic [W_FUNCT-1:0] F_NOR   = 6'h27;
    localparam logic [W_FUNCT-1:0] F_SLT   = 6'h2A;
    localparam logic [W_FUNCT-1:0] F_SLTU  = 6'h2B;

    typedef enum logic [W_PC_SRC-1:0] {
        PC_SRC_NEXT = 2'd0,
        PC_SRC_BRCH = 2'd1,
        PC_SRC_JUMP = 2'd2
    } pc_src_e;

    typedef enum logic [W_MEM_CMD-1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_cmd_e;

    typedef enum logic [W_ALU_SRC-1:0] {
        ALU_SRC_REG = 2'd0,
        ALU_SRC_IMM = 2'd1,
        ALU_SRC_SHA = 2'd2
    } alu_src_e;

    typedef enum logic [W_REG_SRC-1:0] {
        REG_SRC_ALU = 1'b0,
        REG_SRC_MEM = 1'b1
    } reg_src_e;

    typedef struct packed {
        logic [REG_FIELD_W-1:0] wa;
        logic [REG_FIELD_W-1:0] ra1;
        logic [REG_FIELD_W-1:0] ra2;
        logic                   reg_wen;
        logic [W_IMM_EXT-1:0]   imm_ext;
        logic [W_IMM-1:0]       imm;
        logic [W_JADDR-1:0]     addr;
        logic [W_FUNCT-1:0]     alu_op;
        pc_src_e                pc_src;
        mem_cmd_e               mem_cmd;
        alu_src_e               alu_src;
        reg_src_e               reg_src;
        logic                   illegal;
    } ctrl_t;

    function automatic logic [W_OPCODE-1:0] op_of(input logic [INST_W-1:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [W_FUNCT-1:0] funct_of(input logic [INST_W-1:0] inst);
        return inst[5:0];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] rs_of(input logic [INST_W-1:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] rt_of(input logic [INST_W-1:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] rd_of(input logic [INST_W-1:0] inst);
        return inst[15:11];
    endfunction

endpackage

// File: rtl/decode_pipe_lut.sv
// Purely combinational MIPS instruction decoder: instruction word in,
// control word (including the illegal flag) out.
module decode_lut
    import decode_pipe_pkg::*;
(
    input  logic [INST_W-1:0] inst_i,
    output ctrl_t             ctrl_o
);

    logic [W_OPCODE-1:0] op;
    logic [W_FUNCT-1:0]  funct;

    assign op    = op_of(inst_i);
    assign funct = funct_of(inst_i);

    always_comb begin
        // NOTE: the whole word is defaulted before the case so no path can infer a latch.
        ctrl_o      = '0;
        ctrl_o.imm  = inst_i[15:0];
        ctrl_o.addr = inst_i[25:0];

        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_NOR, F_SLT, F_SLTU: begin
                        ctrl_o.wa      = rd_of(inst_i);
                        ctrl_o.ra1     = rs_of(inst_i);
                        ctrl_o.ra2     = rt_of(inst_i);
                        ctrl_o.reg_wen = 1'b1;
                        ctrl_o.alu_op  = funct;
                        ctrl_o.alu_src = ALU_SRC_REG;
                    end
                    F_SLL, F_SRL: begin
                        ctrl_o.wa      = rd_of(inst_i);
                        ctrl_o.ra1     = rt_of(inst_i);
                        ctrl_o.reg_wen = 1'b1;
                        ctrl_o.alu_op  = funct;
                        ctrl_o.alu_src = ALU_SRC_SHA;
                    end
                    F_BREAK: ;
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                ctrl_o.wa      = rt_of(inst_i);
                ctrl_o.ra1     = rs_of(inst_i);
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.alu_src = ALU_SRC_IMM;
                ctrl_o.imm_ext = (op == OP_ANDI || op == OP_ORI) ? 1'b0 : 1'b1;
                case (op)
                    OP_ADDI:  ctrl_o.alu_op = F_ADD;
                    OP_ADDIU: ctrl_o.alu_op = F_ADDU;
                    OP_SLTI:  ctrl_o.alu_op = F_SLT;
                    OP_SLTIU: ctrl_o.alu_op = F_SLTU;
                    OP_ANDI:  ctrl_o.alu_op = F_AND;
                    default:  ctrl_o.alu_op = F_OR;
                endcase
            end
            OP_LW: begin
                ctrl_o.wa      = rt_of(inst_i);
                ctrl_o.ra1     = rs_of(inst_i);
                ctrl_o.reg_wen = 1'b1;
                ctrl_o.imm_ext = 1'b1;
                ctrl_o.alu_op  = F_ADD;
                ctrl_o.alu_src = ALU_SRC_IMM;
                ctrl_o.reg_src = REG_SRC_MEM;
                ctrl_o.mem_cmd = MEM_READ;
            end
            OP_SW: begin
                ctrl_o.ra1     = rs_of(inst_i);
                ctrl_o.ra2     = rt_of(inst_i);
                ctrl_o.imm_ext = 1'b1;
                ctrl_o.alu_op  = F_ADD;
                ctrl_o.alu_src = ALU_SRC_IMM;
                ctrl_o.mem_cmd = MEM_WRITE;
            end
            OP_BEQ: begin
                ctrl_o.ra1     = rs_of(inst_i);
                ctrl_o.ra2     = rt_of(inst_i);
                ctrl_o.imm_ext = 1'b1;
                ctrl_o.alu_op  = F_SUB;
                ctrl_o.alu_src = ALU_SRC_REG;
                ctrl_o.pc_src  = PC_SRC_BRCH;
            end
            OP_J: ctrl_o.pc_src = PC_SRC_JUMP;
            default: ctrl_o.illegal = 1'b1;
        endcase

        // r0 is hardwired, so a write to it is no write at all
        if (ctrl_o.wa == '0) ctrl_o.reg_wen = 1'b0;
    end

endmodule

// File: rtl/decode_pipe.sv
// Registered, valid/ready MIPS decode stage with a RAW/WAW scoreboard.
// Optional `WB_BYPASS_EN: a same-cycle writeback unblocks its register immediately.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int W_CPU    = 32,
    parameter int W_REG    = 5,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W_CPU-1:0]              inst,
    input  logic                          flush,
    input  logic                          wb_valid,
    input  logic [W_REG-1:0]              wb_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W_REG-1:0]              wa,
    output logic [W_REG-1:0]              ra1,
    output logic [W_REG-1:0]              ra2,
    output logic                          reg_wen,
    output logic [W_IMM_EXT-1:0]          imm_ext,
    output logic [W_IMM-1:0]              imm,
    output logic [W_JADDR-1:0]            addr,
    output logic [W_FUNCT-1:0]            alu_op,
    output logic [W_PC_SRC-1:0]           pc_src,
    output logic [W_MEM_CMD-1:0]          mem_cmd,
    output logic [W_ALU_SRC-1:0]          alu_src,
    output logic [W_REG_SRC-1:0]          reg_src,
    output logic                          illegal,
    output logic [$clog2(SB_DEPTH+1)-1:0] pend_cnt
);

    localparam int NUM_REGS = 2 ** W_REG;
    localparam int W_CNT    = $clog2(SB_DEPTH + 1);

    ctrl_t              dec;
    ctrl_t              out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;

    logic [NUM_REGS-1:0] held_mask, wb_mask, set_mask, clr_mask, busy;
    logic               held_wen, full, hazard, accept, issue;
    logic [W_CNT:0]     in_flight;

    decode_lut u_lut (
        .inst_i (inst),
        .ctrl_o (dec)
    );

    assign held_wen = out_valid_q & out_q.reg_wen;
    assign issue    = out_valid_q & out_ready & ~flush;

    always_comb begin
        held_mask = '0;
        wb_mask   = '0;
        set_mask  = '0;
        if (held_wen) held_mask[out_q.wa] = 1'b1;
        if (wb_valid) wb_mask[wb_addr] = 1'b1;
        if (issue && out_q.reg_wen) set_mask[out_q.wa] = 1'b1;
        clr_mask = wb_mask & pending_q;
    end

    // The held word counts against capacity: it enters the scoreboard on issue.
    assign in_flight = {1'b0, cnt_q} + {{W_CNT{1'b0}}, held_wen};
    assign full      = in_flight >= (W_CNT + 1)'(SB_DEPTH);

`ifdef WB_BYPASS_EN
    assign busy = ((pending_q & ~wb_mask) | held_mask) & ~NUM_REGS'(1);
`else
    assign busy = (pending_q | held_mask) & ~NUM_REGS'(1);
`endif

    assign hazard = busy[dec.ra1] | busy[dec.ra2]
                  | (dec.reg_wen & (busy[dec.wa] | full));

    assign in_ready = ~rst & (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) out_d = dec;
        if (flush)       out_valid_d = 1'b0;
        else if (accept) out_valid_d = 1'b1;
        else if (issue)  out_valid_d = 1'b0;

        pending_d = (pending_q | set_mask) & ~clr_mask;
        case ({|set_mask, |clr_mask})
            2'b10:   cnt_d = cnt_q + W_CNT'(1);
            2'b01:   cnt_d = cnt_q - W_CNT'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pending bits are ordinary flops, not a RAM, so they are reset with the rest.
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign wa        = W_REG'(out_q.wa);
    assign ra1       = W_REG'(out_q.ra1);
    assign ra2       = W_REG'(out_q.ra2);
    assign reg_wen   = out_q.reg_wen;
    assign imm_ext   = out_q.imm_ext;
    assign imm       = out_q.imm;
    assign addr      = out_q.addr;
    assign alu_op    = out_q.alu_op;
    assign pc_src    = out_q.pc_src;
    assign mem_cmd   = out_q.mem_cmd;
    assign alu_src   = out_q.alu_src;
    assign reg_src   = out_q.reg_src;
    assign illegal   = out_q.illegal;
    assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode fields, RAW/WAW stalls, capacity,
// back-pressure, flush, illegal opcodes and asynchronous reset.
module tb_decode_pipe;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
    logic [31:0] inst;
    logic [4:0]  wb_addr, wa, ra1, ra2;
    logic        reg_wen, illegal;
    logic [0:0]  imm_ext, reg_src;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [5:0]  alu_op;
    logic [1:0]  pc_src, mem_cmd, alu_src;
    logic [2:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    decode_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wa        (wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .reg_wen   (reg_wen),
        .imm_ext   (imm_ext),
        .imm       (imm),
        .addr      (addr),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .mem_cmd   (mem_cmd),
        .alu_src   (alu_src),
        .reg_src   (reg_src),
        .illegal   (illegal),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_r(input int rt, input int val);
        return 32'h2000_0000 | (32'(rt) << 16) | 32'(val);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pend_cnt", pend_cnt, 0);
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_wa", wa, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        step();

        // ADDI r8,r0,5 then ADD r9,r8,r8
        in_valid = 1'b1; inst = 32'h2008_0005; out_ready = 1'b1; #1;
        chk("t1_addi_ready", in_ready, 1);
        step();
        inst = 32'h0108_4820; #1;
        chk("t1_addi_valid", out_valid, 1);
        chk("t1_addi_wa", wa, 8);
        chk("t1_addi_wen", reg_wen, 1);
        chk("t1_addi_imm", imm, 5);
        chk("t1_addi_ext", imm_ext, 1);
        chk("t1_addi_alusrc", alu_src, 1);
        chk("t1_addi_aluop", alu_op, 32'h20);
        chk("t1_raw_vs_held", in_ready, 0);
        step();
        #1;
        chk("t1_cnt_after_issue", pend_cnt, 1);
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_raw_vs_pending", in_ready, 0);
        wb_valid = 1'b1; wb_addr = 5'd8; #1;
        chk("t1_ready_in_wb_cycle", in_ready, 32'(BYP));
        step();
        wb_valid = 1'b0;
`ifndef WB_BYPASS_EN
        #1;
        chk("t1_cnt_after_wb", pend_cnt, 0);
        chk("t1_ready_after_wb", in_ready, 1);
        step();
`endif
        in_valid = 1'b0; #1;
        chk("t1_add_valid", out_valid, 1);
        chk("t1_add_wa", wa, 9);
        chk("t1_add_ra1", ra1, 8);
        chk("t1_add_ra2", ra2, 8);
        chk("t1_add_alusrc", alu_src, 0);
        chk("t1_cnt_zero", pend_cnt, 0);
        step();
        #1;
        chk("t1_add_pending", pend_cnt, 1);
        wb_valid = 1'b1; wb_addr = 5'd9;
        step();
        wb_valid = 1'b0; #1;
        chk("t1_clean", pend_cnt, 0);

        // five independent writes r1..r5, no writeback
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; inst = addi_r(k, k); #1;
            chk("t2_accept", in_ready, 1);
            step();
        end
        inst = addi_r(5, 5); #1;
        chk("t2_fifth_stall_held", in_ready, 0);
        step();
        #1;
        chk("t2_cnt_full", pend_cnt, 4);
        chk("t2_valid_drop", out_valid, 0);
        chk("t2_fifth_stall_full", in_ready, 0);
        step();
        wb_valid = 1'b1; wb_addr = 5'd1; #1;
        chk("t2_stall_wb_cycle", in_ready, 0);
        step();
        wb_valid = 1'b0; #1;
        chk("t2_cnt_after_wb", pend_cnt, 3);
        chk("t2_fifth_ready", in_ready, 1);
        step();
        in_valid = 1'b0; #1;
        chk("t2_fifth_valid", out_valid, 1);
        chk("t2_fifth_wa", wa, 5);
        step();
        #1;
        chk("t2_cnt_refull", pend_cnt, 4);
        for (int k = 2; k <= 5; k++) begin
            wb_valid = 1'b1; wb_addr = 5'(k);
            step();
        end
        wb_valid = 1'b0; #1;
        chk("t2_clean", pend_cnt, 0);

        // ORI r10 held under back-pressure
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h340A_F0F0; #1;
        chk("t3_ori_ready", in_ready, 1);
        step();
        inst = 32'h300B_00FF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_wa", wa, 10);
            chk("t3_hold_imm", imm, 32'hF0F0);
            chk("t3_hold_ext", imm_ext, 0);
            chk("t3_hold_aluop", alu_op, 32'h25);
            chk("t3_hold_ready", in_ready, 0);
            chk("t3_hold_cnt", pend_cnt, 0);
            step();
        end
        out_ready = 1'b1; #1;
        chk("t3_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0; #1;
        chk("t3_ori_issued", pend_cnt, 1);
        chk("t3_andi_valid", out_valid, 1);
        chk("t3_andi_wa", wa, 11);
        chk("t3_andi_aluop", alu_op, 32'h24);
        step();
        #1;
        chk("t3_andi_issued", pend_cnt, 2);
        wb_valid = 1'b1; wb_addr = 5'd10;
        step();
        wb_addr = 5'd11;
        step();
        wb_valid = 1'b0; #1;
        chk("t3_clean", pend_cnt, 0);

        // flush of a held SW, with r7 already pending
        in_valid = 1'b1; inst = addi_r(7, 7);
        step();
        inst = 32'hAC62_0008;
        step();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("t4_sw_valid", out_valid, 1);
        chk("t4_sw_memcmd", mem_cmd, 2);
        chk("t4_sw_wen", reg_wen, 0);
        chk("t4_sw_ra1", ra1, 3);
        chk("t4_sw_ra2", ra2, 2);
        chk("t4_sw_imm", imm, 8);
        step();
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; inst = 32'h340C_0001; #1;
        chk("t4_ready_in_flush", in_ready, 0);
        step();
        flush = 1'b0; #1;
        chk("t4_flushed", out_valid, 0);
        chk("t4_cnt_kept", pend_cnt, 1);
        chk("t4_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0; #1;
        chk("t4_next_valid", out_valid, 1);
        chk("t4_next_wa", wa, 12);
        step();
        #1;
        chk("t4_cnt", pend_cnt, 2);
        wb_valid = 1'b1; wb_addr = 5'd7;
        step();
        wb_addr = 5'd12;
        step();
        wb_valid = 1'b0; #1;
        chk("t4_clean", pend_cnt, 0);

        // illegal opcode, then BEQ, J, SLL, write to r0, LW back to back
        in_valid = 1'b1; inst = 32'hFC22_1234; #1;
        chk("t5_ill_ready", in_ready, 1);
        step();
        inst = 32'h1022_0003; #1;
        chk("t5_ill_flag", illegal, 1);
        chk("t5_ill_wen", reg_wen, 0);
        chk("t5_ill_memcmd", mem_cmd, 0);
        chk("t5_ill_pcsrc", pc_src, 0);
        step();
        inst = 32'h0800_0100; #1;
        chk("t5_ill_no_sb", pend_cnt, 0);
        chk("t5_beq_illegal", illegal, 0);
        chk("t5_beq_pcsrc", pc_src, 1);
        chk("t5_beq_aluop", alu_op, 32'h22);
        chk("t5_beq_ra1", ra1, 1);
        chk("t5_beq_ra2", ra2, 2);
        chk("t5_beq_wen", reg_wen, 0);
        step();
        inst = 32'h0004_1880; #1;
        chk("t5_j_pcsrc", pc_src, 2);
        chk("t5_j_addr", addr, 32'h100);
        chk("t5_j_wen", reg_wen, 0);
        step();
        inst = 32'h2020_0001; #1;
        chk("t5_sll_wa", wa, 3);
        chk("t5_sll_ra1", ra1, 4);
        chk("t5_sll_ra2", ra2, 0);
        chk("t5_sll_alusrc", alu_src, 2);
        chk("t5_sll_wen", reg_wen, 1);
        step();
        inst = 32'h8CA4_0004; #1;
        chk("t5_r0_wen", reg_wen, 0);
        chk("t5_r0_ra1", ra1, 1);
        chk("t5_lw_ready", in_ready, 1);
        step();
        in_valid = 1'b0; #1;
        chk("t5_lw_regsrc", reg_src, 1);
        chk("t5_lw_memcmd", mem_cmd, 1);
        chk("t5_lw_wa", wa, 4);
        chk("t5_lw_ra1", ra1, 5);
        chk("t5_lw_ext", imm_ext, 1);
        step();
        #1;
        chk("t5_cnt", pend_cnt, 2);
        wb_valid = 1'b1; wb_addr = 5'd3;
        step();
        wb_addr = 5'd4;
        step();
        wb_addr = 5'd20;
        step();
        wb_valid = 1'b0; #1;
        chk("t5_stray_wb_ignored", pend_cnt, 0);

        // asynchronous reset in the middle of a RAW stall, 3 pending
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; inst = addi_r(k, k);
            step();
        end
        out_ready = 1'b0; inst = 32'h0021_4820; #1;
        chk("t6_pre_cnt", pend_cnt, 3);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_stall", in_ready, 0);
        #1; rst = 1'b1; #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_cnt", pend_cnt, 0);
        chk("t6_rst_wen", reg_wen, 0);
        chk("t6_rst_wa", wa, 0);
        chk("t6_rst_imm", imm, 0);
        chk("t6_rst_ready", in_ready, 0);
        step();
        rst = 1'b0; #1;
        chk("t6_post_ready", in_ready, 1);
        step();
        #1;
        chk("t6_post_valid", out_valid, 1);
        chk("t6_post_wa", wa, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
